// File: rtl/stream_mux_arb_if.sv
// Handshake bundle for stream_mux_arb: per-channel input streams, mode/select
// controls, and the single registered output stream.
// The slave modport is the arbiter's view. The master modport is the view of
// the block driving the inputs and consuming the output.
interface stream_mux_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 8,
    parameter int SEL_WIDTH  = $clog2(NUM_CH)
);
    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_last;
    logic [NUM_CH-1:0]            in_ready;
    logic [SEL_WIDTH-1:0]         sel;
    logic                         mode;
    logic [DATA_WIDTH-1:0]        out_data;
    logic                         out_last;
    logic                         out_valid;
    logic                         out_ready;
    logic [SEL_WIDTH-1:0]         out_ch;
    logic                         busy;

    modport slave (
        input  in_data, in_valid, in_last, sel, mode, out_ready,
        output in_ready, out_data, out_last, out_valid, out_ch, busy
    );

    modport master (
        output in_data, in_valid, in_last, sel, mode, out_ready,
        input  in_ready, out_data, out_last, out_valid, out_ch, busy
    );
endinterface

// File: rtl/stream_mux_arb.sv
// Packet-aware stream multiplexer.
// Once the first beat of a packet is accepted, the arbiter locks onto that
// channel until the last beat. The output stage is a single register slice
// that can drain and load in the same cycle.
// Round-robin arbitration and its pointer exist only when STREAM_MUX_RR_EN is
// defined. Without it, the block always selects by SEL.
//
// state  | meaning
// IDLE   | no packet open; grant is chosen from SEL or by round-robin
// LOCKED | packet open; grant is held on the latched channel until LAST
module stream_mux_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 8,
    parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
    input logic             clk,
    input logic             rst,
    stream_mux_arb_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [SEL_WIDTH-1:0]  lock_ch_q, lock_ch_d;
    logic [SEL_WIDTH-1:0]  grant_ch;
    logic                  grant_vld;
    logic                  g_valid, g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  load_en, accept;
    logic [NUM_CH-1:0]     in_ready_c;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_last_q, out_valid_q;
    logic [SEL_WIDTH-1:0]  out_ch_q;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
`else
    logic                  unused_mode;
    assign unused_mode = bus.mode;
`endif

    // The output slot can take a new beat when it is empty or is draining this cycle.
    assign load_en = !out_valid_q || bus.out_ready;

    // Grant selection: a locked channel wins; otherwise round-robin or SEL.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        if (state_q == LOCKED) begin
            grant_vld = 1'b1;
            grant_ch  = lock_ch_q;
        end
`ifdef STREAM_MUX_RR_EN
        else if (bus.mode) begin
            // Search starts one past the last channel served, and wraps around.
            for (int i = 1; i <= NUM_CH; i++) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (!grant_vld && bus.in_valid[k] &&
                        ((int'(ptr_q) + i) % NUM_CH) == k) begin
                        grant_vld = 1'b1;
                        grant_ch  = SEL_WIDTH'(k);
                    end
                end
            end
        end
`endif
        else begin
            // A SEL value beyond the last channel matches no channel, so no grant is made.
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.sel == SEL_WIDTH'(k) && bus.in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant_ch  = SEL_WIDTH'(k);
                end
            end
        end
    end

    // Route the granted channel's beat and produce the one-hot ready.
    always_comb begin
        g_valid    = 1'b0;
        g_last     = 1'b0;
        g_data     = '0;
        in_ready_c = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_ch == SEL_WIDTH'(k)) begin
                g_valid = bus.in_valid[k];
                g_last  = bus.in_last[k];
                g_data  = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
            in_ready_c[k] = !rst && load_en && grant_vld && (grant_ch == SEL_WIDTH'(k));
        end
    end

    assign accept = grant_vld && g_valid && load_en;

    // Next-state logic: open a packet on a non-last beat, close it on the last beat.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        case (state_q)
            IDLE: begin
                if (accept && !g_last) begin
                    state_d   = LOCKED;
                    lock_ch_d = grant_ch;
                end
            end
            LOCKED: begin
                if (accept && g_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and locked-channel register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end

`ifdef STREAM_MUX_RR_EN
    // The pointer records the channel that started the most recent round-robin packet.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && accept && bus.mode) begin
            ptr_d = grant_ch;
        end
    end

    // Round-robin pointer register. Its reset value makes channel 0 the first candidate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= SEL_WIDTH'(NUM_CH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Output slice: holds while stalled, and otherwise loads the accepted beat or empties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (load_en) begin
            out_valid_q <= accept;
            if (accept) begin
                out_last_q <= g_last;
                out_data_q <= g_data;
                out_ch_q   <= grant_ch;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.busy      = (state_q == LOCKED);
endmodule
